// File: rtl/temp_sample_filter.sv
//==============================================================================
// temp_sample_filter: ADT7420 reading -> block average, min/max, alarms, PC word
// Rev 1.0
//==============================================================================
`default_nettype none

module temp_sample_filter #(
  parameter logic signed [15:0] T_HIGH = 16'sd480,
  parameter logic signed [15:0] T_LOW  = 16'sd0,
  parameter logic signed [15:0] HYST   = 16'sd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_raw,
  input  logic [2:0]  avg_log2,
  input  logic        clear,
  output logic [31:0] PC_tx,
  output logic        avg_valid,
  output logic [15:0] min_temp,
  output logic [15:0] max_temp,
  output logic        alarm_high,
  output logic        alarm_low
);

  typedef enum logic [0:0] {ACCUM = 1'b0, DIVIDE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic signed [19:0] acc_q, acc_d;
  logic [7:0]         count_q, count_d;
  logic [2:0]         klat_q, klat_d;
  logic signed [15:0] min_q, min_d, max_q, max_d;
  logic               mmv_q, mmv_d;
  logic               s1_valid_q, s1_valid_d;
  logic signed [15:0] s1_avg_q, s1_avg_d;
  logic [31:0]        pc_tx_q, pc_tx_d;
  logic               avg_valid_q, avg_valid_d;
  logic               ahigh_q, ahigh_d, alow_q, alow_d;
  logic [7:0]         seq_q, seq_d;

  logic signed [15:0] w_t;
  logic signed [19:0] w_t_ext, w_rnd, w_sum, w_base_acc;
  logic signed [15:0] w_avg;
  logic               w_accept, w_start, w_ah, w_al;
  logic [2:0]         w_k;
  logic [7:0]         w_base_cnt, w_cnt_inc, w_len;

  // Arithmetic shift of the raw word keeps the sign of bits [15:3].
  assign w_t      = $signed(sample_raw) >>> 3;
  assign w_t_ext  = {{4{w_t[15]}}, w_t};
  assign w_accept = sample_valid & ~clear;
  // A window restarts on its first sample, including one arriving during DIVIDE.
  assign w_start    = (state_q == DIVIDE) || (count_q == 8'd0);
  assign w_k        = w_start ? avg_log2 : klat_q;
  assign w_len      = 8'd1 << w_k;
  assign w_base_acc = w_start ? 20'sd0 : acc_q;
  assign w_base_cnt = w_start ? 8'd0 : count_q;
  assign w_cnt_inc  = w_base_cnt + 8'd1;
  assign w_rnd      = (klat_q == 3'd0) ? 20'sd0 : (20'sd1 <<< (klat_q - 3'd1));
  assign w_sum      = acc_q + w_rnd;
  assign w_avg      = 16'(w_sum >>> klat_q);

  always_comb begin
    w_ah = ahigh_q;
    w_al = alow_q;
    if (s1_avg_q > T_HIGH)             w_ah = 1'b1;
    else if (s1_avg_q < T_HIGH - HYST) w_ah = 1'b0;
    if (s1_avg_q < T_LOW)              w_al = 1'b1;
    else if (s1_avg_q > T_LOW + HYST)  w_al = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    klat_d      = klat_q;
    min_d       = min_q;
    max_d       = max_q;
    mmv_d       = mmv_q;
    s1_valid_d  = 1'b0;
    s1_avg_d    = s1_avg_q;
    pc_tx_d     = pc_tx_q;
    avg_valid_d = s1_valid_q;
    ahigh_d     = ahigh_q;
    alow_d      = alow_q;
    seq_d       = seq_q;

    if (state_q == DIVIDE) begin
      s1_valid_d = 1'b1;
      s1_avg_d   = w_avg;
      state_d    = ACCUM;
      acc_d      = 20'sd0;
      count_d    = 8'd0;
    end

    if (w_accept) begin
      acc_d   = w_base_acc + w_t_ext;
      count_d = w_cnt_inc;
      klat_d  = w_k;
      state_d = (w_cnt_inc == w_len) ? DIVIDE : ACCUM;
      if (!mmv_q || w_t < min_q) min_d = w_t;
      if (!mmv_q || w_t > max_q) max_d = w_t;
      mmv_d = 1'b1;
    end

    // Output stage: second cycle of the average pipeline.
    if (s1_valid_q) begin
      ahigh_d = w_ah;
      alow_d  = w_al;
      seq_d   = seq_q + 8'd1;
      pc_tx_d = {5'b0, w_al, w_ah, mmv_q, seq_q + 8'd1, s1_avg_q};
    end

    if (clear) begin
      state_d     = ACCUM;
      acc_d       = 20'sd0;
      count_d     = 8'd0;
      min_d       = 16'sh7FFF;
      max_d       = 16'sh8000;
      mmv_d       = 1'b0;
      s1_valid_d  = 1'b0;
      pc_tx_d     = 32'd0;
      avg_valid_d = 1'b0;
      ahigh_d     = 1'b0;
      alow_d      = 1'b0;
      seq_d       = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= 20'sd0;
      count_q     <= 8'd0;
      klat_q      <= 3'd0;
      min_q       <= 16'sh7FFF;
      max_q       <= 16'sh8000;
      mmv_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_avg_q    <= 16'sd0;
      pc_tx_q     <= 32'd0;
      avg_valid_q <= 1'b0;
      ahigh_q     <= 1'b0;
      alow_q      <= 1'b0;
      seq_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      klat_q      <= klat_d;
      min_q       <= min_d;
      max_q       <= max_d;
      mmv_q       <= mmv_d;
      s1_valid_q  <= s1_valid_d;
      s1_avg_q    <= s1_avg_d;
      pc_tx_q     <= pc_tx_d;
      avg_valid_q <= avg_valid_d;
      ahigh_q     <= ahigh_d;
      alow_q      <= alow_d;
      seq_q       <= seq_d;
    end
  end

  assign PC_tx      = pc_tx_q;
  assign avg_valid  = avg_valid_q;
  assign min_temp   = min_q;
  assign max_temp   = max_q;
  assign alarm_high = ahigh_q;
  assign alarm_low  = alow_q;

endmodule

`default_nettype wire

// File: tb/tb_temp_sample_filter.sv
//==============================================================================
// tb_temp_sample_filter: directed self-checking bench for temp_sample_filter
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_temp_sample_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_raw = 16'd0;
  logic [2:0]  avg_log2 = 3'd0;
  logic        clear = 1'b0;
  logic [31:0] PC_tx;
  logic        avg_valid;
  logic [15:0] min_temp, max_temp;
  logic        alarm_high, alarm_low;

  int checks = 0;
  int failures = 0;

  temp_sample_filter dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_raw(sample_raw),
    .avg_log2(avg_log2), .clear(clear), .PC_tx(PC_tx), .avg_valid(avg_valid),
    .min_temp(min_temp), .max_temp(max_temp), .alarm_high(alarm_high), .alarm_low(alarm_low)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the sample is captured by the following posedge.
  task automatic put(input logic [15:0] raw);
    sample_valid = 1'b1;
    sample_raw   = raw;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_avg(output int cyc);
    cyc = 0;
    while (!avg_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (PC_tx !== 32'd0 || avg_valid !== 1'b0 || alarm_high !== 1'b0 || alarm_low !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: PC_tx=%h avg_valid=%b ah=%b al=%b, required 0", PC_tx, avg_valid, alarm_high, alarm_low);
    end
    checks++;
    if (min_temp !== 16'h7FFF || max_temp !== 16'h8000) begin
      failures++;
      $display("FAIL reset_minmax: min=%h max=%h, required 7fff/8000", min_temp, max_temp);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_avg_basic();
    avg_log2 = 3'd2;
    put(16'h0C80); put(16'h0C88); put(16'h0C90); put(16'h0C90);
    @(negedge clk);
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency_early: avg_valid=%b one cycle after capture, required 0", avg_valid);
    end
    @(negedge clk);
    checks++;
    if (avg_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: avg_valid=%b two cycles after capture, required 1", avg_valid);
    end
    checks++;
    if (PC_tx !== 32'h0101_0191) begin
      failures++;
      $display("FAIL basic_pc_tx: got %h, required 01010191", PC_tx);
    end
    checks++;
    if (min_temp !== 16'h0190 || max_temp !== 16'h0192) begin
      failures++;
      $display("FAIL basic_minmax: min=%h max=%h, required 0190/0192", min_temp, max_temp);
    end
    @(negedge clk);
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse_width: avg_valid=%b, required 0", avg_valid);
    end
  endtask

  task automatic test_negative();
    int cyc;
    do_clear();
    avg_log2 = 3'd1;
    put(16'hFB00); put(16'hFAF8);
    wait_avg(cyc);
    checks++;
    if (cyc >= 50) begin
      failures++;
      $display("FAIL neg_timeout: no avg_valid within %0d cycles, required pulse", cyc);
    end
    checks++;
    if (PC_tx !== 32'h0501_FF60) begin
      failures++;
      $display("FAIL neg_pc_tx: got %h, required 0501ff60", PC_tx);
    end
    checks++;
    if (min_temp !== 16'hFF5F || max_temp !== 16'hFF60 || alarm_low !== 1'b1) begin
      failures++;
      $display("FAIL neg_minmax_alarm: min=%h max=%h al=%b, required ff5f/ff60/1", min_temp, max_temp, alarm_low);
    end
  endtask

  task automatic test_alarms();
    logic [15:0] raws [6] = '{16'h0F08, 16'h0EB0, 16'h0E78, 16'hFFF8, 16'h0050, 16'h0088};
    logic [15:0] avgs [6] = '{16'd481, 16'd470, 16'd463, 16'hFFFF, 16'd10, 16'd17};
    logic        exp_h [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_l [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int cyc;
    do_clear();
    avg_log2 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      put(raws[i]);
      wait_avg(cyc);
      checks++;
      if (cyc >= 50 || PC_tx[15:0] !== avgs[i] || alarm_high !== exp_h[i] || alarm_low !== exp_l[i]) begin
        failures++;
        $display("FAIL alarm_step%0d: avg=%h ah=%b al=%b cyc=%0d, required avg=%h ah=%b al=%b",
                 i, PC_tx[15:0], alarm_high, alarm_low, cyc, avgs[i], exp_h[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_clear();
    avg_log2 = 3'd0;
    sample_raw = 16'h0080;
    for (int i = 0; i < 310; i++) begin
      sample_valid = (i < 300);
      @(negedge clk);
      if (avg_valid) pulses++;
    end
    sample_valid = 1'b0;
    checks++;
    if (pulses != 300) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d, required 300", pulses);
    end
    checks++;
    if (PC_tx[23:16] !== 8'd44 || PC_tx[15:0] !== 16'd16) begin
      failures++;
      $display("FAIL b2b_seq_avg: seq=%0d avg=%h, required 44/0010", PC_tx[23:16], PC_tx[15:0]);
    end
  endtask

  task automatic test_clear_window();
    int seen = 0;
    int cyc;
    avg_log2 = 3'd3;
    repeat (5) put(16'h0C80);
    clear = 1'b1;
    sample_valid = 1'b1;
    sample_raw = 16'h0C80;
    @(negedge clk);
    clear = 1'b0;
    sample_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (avg_valid) seen++;
    end
    checks++;
    if (seen != 0 || PC_tx !== 32'd0) begin
      failures++;
      $display("FAIL clear_no_avg: pulses=%0d PC_tx=%h, required 0/00000000", seen, PC_tx);
    end
    checks++;
    if (min_temp !== 16'h7FFF || max_temp !== 16'h8000) begin
      failures++;
      $display("FAIL clear_minmax: min=%h max=%h, required 7fff/8000", min_temp, max_temp);
    end
    repeat (8) put(16'h0C80);
    wait_avg(cyc);
    checks++;
    if (cyc >= 50 || PC_tx !== 32'h0101_0190) begin
      failures++;
      $display("FAIL clear_next_window: PC_tx=%h cyc=%0d, required 01010190", PC_tx, cyc);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    avg_log2 = 3'd2;
    put(16'h0C80); put(16'h0C80);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (PC_tx !== 32'd0 || avg_valid !== 1'b0 || alarm_high !== 1'b0 || alarm_low !== 1'b0 ||
        min_temp !== 16'h7FFF || max_temp !== 16'h8000) begin
      failures++;
      $display("FAIL async_reset: PC_tx=%h av=%b ah=%b al=%b min=%h max=%h, required reset values",
               PC_tx, avg_valid, alarm_high, alarm_low, min_temp, max_temp);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    put(16'h0C80);
    avg_log2 = 3'd0;
    put(16'h0C88); put(16'h0C90); put(16'h0C90);
    wait_avg(cyc);
    checks++;
    if (cyc != 2 || PC_tx !== 32'h0101_0191) begin
      failures++;
      $display("FAIL post_reset_window: PC_tx=%h cyc=%0d, required 01010191 after 2", PC_tx, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_avg_basic();
    test_negative();
    test_alarms();
    test_back_to_back();
    test_clear_window();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/temp_sample_filter.md
Name: temp_sample_filter

Overview:
- Sits downstream of the temperature-sensor controller, between its completed 16-bit ADT7420 readings and the 32-bit PC wire-out word (endpoint 0x20).
- Converts each raw 13-bit reading to signed 1/16 °C, block-averages 2^k samples, and tracks min/max since the last clear.
- Evaluates high/low alarms with hysteresis and packs the result plus a sequence counter into PC_tx.

Parameters:
- T_HIGH, 16'sd480, high alarm threshold in 1/16 °C (30 °C).
- T_LOW, 16'sd0, low alarm threshold in 1/16 °C (0 °C).
- HYST, 16'sd16, alarm release hysteresis in 1/16 °C (1 °C).

Ports:
- clk  in  1  system clock (single domain).
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle pulse: sample_raw holds a new reading.
- sample_raw  in  16  {MSB byte, LSB byte} of ADT7420 reg 0x00/0x01; bits [15:3] = 13-bit two's complement temperature.
- avg_log2  in  3  window size k; window = 2^k samples (1..128). Taken from PC_rx.
- clear  in  1  synchronous clear of statistics and window. Taken from PC_rx.
- PC_tx  out  32  {5'b0, alarm_low, alarm_high, minmax_valid, seq[7:0], avg[15:0]}.
- avg_valid  out  1  one-cycle pulse when PC_tx is updated.
- min_temp  out  16  signed minimum since clear.
- max_temp  out  16  signed maximum since clear.
- alarm_high  out  1  high alarm state.
- alarm_low  out  1  low alarm state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - PC_tx = 0, avg_valid = 0, alarm_high = 0, alarm_low = 0, seq = 0.
  - acc = 0, count = 0, state = ACCUM.
  - min_temp = 16'h7FFF, max_temp = 16'h8000, minmax_valid = 0.
- Conversion: t = sign-extend sample_raw[15:3] to 16 bits. sample_raw[2:0] is ignored.
- Accumulator: 20-bit signed, 13 bits plus 7 growth bits. It cannot overflow for k ≤ 7.
- FSM has two states, ACCUM and DIVIDE.
- ACCUM:
  - Window k_lat is latched from avg_log2 when count == 0 and a sample is accepted.
  - Each sample_valid adds t to acc and increments count.
  - When count reaches 2^k_lat, go to DIVIDE on the next edge.
- DIVIDE (exactly 1 cycle):
  - avg = (acc + (k_lat > 0 ? 1 << (k_lat-1) : 0)) >>> k_lat, i.e. round half toward +inf. avg is truncated to 16 bits, and the result always fits.
  - PC_tx is registered, seq increments (wraps 255→0), avg_valid pulses, alarms update, then the FSM returns to ACCUM.
  - A sample_valid arriving in DIVIDE is not lost: it becomes the first sample of the next window (acc = t, count = 1, k_lat re-latched).
- Latency: avg_valid is asserted 2 cycles after the clock edge that captured the window's last sample.
- Min/max: updated on every accepted sample, independent of the window.
  - The first sample after reset or clear loads both min and max and sets minmax_valid.
- Alarms (evaluated only on a new avg):
  - alarm_high sets when avg > T_HIGH and clears when avg < T_HIGH − HYST; otherwise it holds.
  - alarm_low sets when avg < T_LOW and clears when avg > T_LOW + HYST; otherwise it holds.
- Changing avg_log2 mid-window has no effect until the next window starts.
- clear (synchronous, highest priority over sample_valid):
  - acc, count, seq, alarms, min/max and minmax_valid return to their reset values; state = ACCUM.
  - PC_tx is rewritten to 0 and avg_valid is not pulsed.
  - A sample coinciding with clear is discarded.
- Reset mid-window discards the partial window with no avg_valid pulse.

Test Plan:
1. avg_log2=2; samples 0x0C80, 0x0C88, 0x0C90, 0x0C90 (400, 401, 402, 402) -> sum 1605, avg_valid two cycles after the 4th sample, PC_tx = 0x0000_0191 | seq 1 in [23:16] | minmax_valid; min_temp = 0x0190, max_temp = 0x0192.
2. avg_log2=1; samples 0xFB00 (−160), 0xFAF8 (−161) -> sum −321, avg = −160 = 0xFF60; min_temp = 0xFF5F, max_temp = 0xFF60.
3. avg_log2=0; successive avgs of 481, 470, 463 -> alarm_high goes 1, stays 1, clears to 0. Then −1, 10, 17 -> alarm_low goes 1, stays 1, clears to 0.
4. avg_log2=0; sample_valid asserted every cycle for 300 cycles -> 300 avg_valid pulses, none dropped; seq wraps so final seq = 300 mod 256 = 44.
5. avg_log2=3; 5 samples, then clear coinciding with a 6th sample -> no avg_valid, PC_tx = 0, min/max = 0x7FFF/0x8000. The next 8 samples of 400 give avg 400 with seq 1.
6. rst_n low mid-window for 1 cycle with no clock edge -> all outputs return to reset values immediately. 2^k further samples give one avg with seq 1.
